// File: rtl/traffic_analyzer_capture_ctrl_if.sv
// Capture controller bus: GMII RX tap, timebase, arm control,
// CPU-side buffer read port and capture status.
interface traffic_analyzer_capture_ctrl_if #(
  parameter int BUF_ADDR_WIDTH = 8
);
  logic [7:0]                gmii_rxd;
  logic                      gmii_rx_dv;
  logic                      gmii_rx_er;
  logic                      arm;
  logic [63:0]               ts_sec;
  logic [31:0]               ts_nsec;
  logic [BUF_ADDR_WIDTH-1:0] rd_addr;
  logic [31:0]               rd_data;
  logic [31:0]               frame_size;
  logic [63:0]               timestamp_sec;
  logic [31:0]               timestamp_nsec;
  logic                      busy;
  logic                      done;
  logic                      truncated;
  logic                      rx_error;

  modport master (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er, arm,
    output ts_sec, ts_nsec, rd_addr,
    input  rd_data, frame_size, timestamp_sec,
    input  timestamp_nsec, busy, done, truncated, rx_error
  );

  modport slave (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er, arm,
    input  ts_sec, ts_nsec, rd_addr,
    output rd_data, frame_size, timestamp_sec,
    output timestamp_nsec, busy, done, truncated, rx_error
  );
endinterface

// File: rtl/traffic_analyzer_capture_ctrl.sv
// Single-shot GMII frame capture: waits for a frame boundary, strips
// preamble/SFD and packs bytes big-endian into a 32-bit word buffer.
module traffic_analyzer_capture_ctrl #(
  parameter int BUF_ADDR_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  traffic_analyzer_capture_ctrl_if.slave bus
);
  localparam int         DEPTH = 1 << BUF_ADDR_WIDTH;
  localparam logic [7:0] SFD   = 8'hD5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,
    S_ARMED,
    S_PRE,
    S_CAP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_cnt;
  logic [31:0] r_word;
  logic [31:0] r_frame_size;
  logic [63:0] r_ts_sec;
  logic [31:0] r_ts_nsec;
  logic [31:0] r_rd_data;
  logic        r_trunc;
  logic        r_rx_err;
  logic [31:0] r_mem [DEPTH];

  logic                      w_arm_ok;
  logic                      w_sfd;
  logic                      w_byte;
  logic                      w_eof;
  logic                      w_in_range;
  logic                      w_we;
  logic [BUF_ADDR_WIDTH-1:0] w_waddr;
  logic [31:0]               w_wdata;

  // Byte index r_cnt still fits in the buffer (no wrap past the end).
  assign w_in_range = (r_cnt >> (BUF_ADDR_WIDTH + 2)) == '0;
  assign w_waddr    = r_cnt[BUF_ADDR_WIDTH+1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_arm_ok = 1'b0;
    w_sfd    = 1'b0;
    w_byte   = 1'b0;
    w_eof    = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.arm) begin
          w_arm_ok = 1'b1;
          w_next   = bus.gmii_rx_dv ? S_SKIP : S_ARMED;
        end
      end
      S_SKIP: begin
        if (!bus.gmii_rx_dv) w_next = S_ARMED;
      end
      S_ARMED, S_PRE: begin
        if (!bus.gmii_rx_dv) begin
          w_next = S_ARMED;
        end else if (bus.gmii_rxd == SFD) begin
          w_sfd  = 1'b1;
          w_next = S_CAP;
        end else begin
          w_next = S_PRE;
        end
      end
      S_CAP: begin
        if (bus.gmii_rx_dv) begin
          w_byte = 1'b1;
        end else begin
          w_eof  = 1'b1;
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_we    = 1'b0;
    w_wdata = {r_word[23:0], bus.gmii_rxd};
    if (w_byte) begin
      w_we = w_in_range && (r_cnt[1:0] == 2'd3);
    end else if (w_eof) begin
      w_we = w_in_range && (r_cnt[1:0] != 2'd0);
      unique case (r_cnt[1:0])
        2'd1:    w_wdata = {r_word[7:0], 24'h0};
        2'd2:    w_wdata = {r_word[15:0], 16'h0};
        2'd3:    w_wdata = {r_word[23:0], 8'h0};
        default: w_wdata = r_word;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_word       <= '0;
      r_frame_size <= '0;
      r_ts_sec     <= '0;
      r_ts_nsec    <= '0;
      r_trunc      <= 1'b0;
      r_rx_err     <= 1'b0;
    end else begin
      if (w_arm_ok) begin
        r_frame_size <= '0;
        r_trunc      <= 1'b0;
        r_rx_err     <= 1'b0;
      end
      if (w_sfd) begin
        r_cnt     <= '0;
        r_ts_sec  <= bus.ts_sec;
        r_ts_nsec <= bus.ts_nsec;
      end
      if (w_byte) begin
        r_word <= {r_word[23:0], bus.gmii_rxd};
        if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
        if (!w_in_range) r_trunc <= 1'b1;
      end
      if (r_state == S_CAP && bus.gmii_rx_er) r_rx_err <= 1'b1;
      if (w_eof) r_frame_size <= r_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_data <= '0;
    else       r_rd_data <= r_mem[bus.rd_addr];
  end

  assign bus.rd_data        = r_rd_data;
  assign bus.frame_size     = r_frame_size;
  assign bus.timestamp_sec  = r_ts_sec;
  assign bus.timestamp_nsec = r_ts_nsec;
  assign bus.truncated      = r_trunc;
  assign bus.rx_error       = r_rx_err;
  assign bus.done           = (r_state == S_DONE);
  assign bus.busy           = (r_state inside {S_SKIP, S_ARMED, S_PRE, S_CAP});
endmodule

// File: tb/tb_traffic_analyzer_capture_ctrl.sv
// Scoreboard bench: stimulus pushes expected capture results, a monitor
// pops them on each rising done and reads back the buffer.
module tb_traffic_analyzer_capture_ctrl;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [31:0] size;
    logic        trunc;
    logic        rxerr;
    logic [63:0] sec;
    logic [31:0] nsec;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  traffic_analyzer_capture_ctrl_if #(.BUF_ADDR_WIDTH(AW)) bus();

  traffic_analyzer_capture_ctrl #(.BUF_ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sb[$];
  logic [31:0] mdl [DEPTH];
  bit          known [DEPTH];
  logic [7:0]  pl[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_push = 0;
  int          n_mon  = 0;
  logic [63:0] last_sec;
  logic [31:0] last_nsec;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic dv, input logic [7:0] d, input logic er);
    bus.gmii_rx_dv = dv;
    bus.gmii_rxd   = d;
    bus.gmii_rx_er = er;
    bus.ts_sec     = {$urandom, $urandom};
    bus.ts_nsec    = $urandom;
    last_sec       = bus.ts_sec;
    last_nsec      = bus.ts_nsec;
    @(posedge clk);
    #1;
  endtask

  // Buffer contents implied by the payload: byte n in word n/4, MSB first,
  // nothing beyond the buffer end, zero padding in a trailing partial word.
  task automatic model_store(input int n, input bit full_only);
    int          nw;
    logic [31:0] v;
    nw = full_only ? n / 4 : (n + 3) / 4;
    for (int w = 0; w < nw && w < DEPTH; w++) begin
      v = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) v[31-8*k -: 8] = pl[4*w+k];
      mdl[w]   = v;
      known[w] = 1'b1;
    end
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    bus.arm = 1'b0;
    chk("busy_after_arm", bus.busy, 1);
    chk("done_clr_on_arm", bus.done, 0);
    chk("size_clr_on_arm", bus.frame_size, 0);
  endtask

  task automatic send_frame(input int npre, input int er_at);
    exp_t e;
    bit   erx;
    erx = 1'b0;
    for (int i = 0; i < npre; i++) cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'hD5, 1'b0);
    e.sec  = last_sec;
    e.nsec = last_nsec;
    for (int i = 0; i < pl.size(); i++) begin
      cyc(1'b1, pl[i], i == er_at);
      if (i == er_at) erx = 1'b1;
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("done_after_eof", bus.done, 1);
    chk("busy_after_eof", bus.busy, 0);
    e.size  = pl.size();
    e.trunc = pl.size() > 4 * DEPTH;
    e.rxerr = erx;
    model_store(pl.size(), 1'b0);
    sb.push_back(e);
    n_push++;
    for (int i = 0; i < 4000 && n_mon < n_push; i++)
      cyc(1'b0, 8'h00, 1'b0);
    chk("monitor_timeout", n_mon, n_push);
  endtask

  task automatic fill_seq(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(i[7:0]);
  endtask

  task automatic fill_rand(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rd_data"}, bus.rd_data, 0);
    chk({tag, "_frame_size"}, bus.frame_size, 0);
    chk({tag, "_ts_sec"}, bus.timestamp_sec, 0);
    chk({tag, "_ts_nsec"}, bus.timestamp_nsec, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_truncated"}, bus.truncated, 0);
    chk({tag, "_rx_error"}, bus.rx_error, 0);
  endtask

  initial begin : monitor
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("frame_size", bus.frame_size, e.size);
          chk("truncated", bus.truncated, e.trunc);
          chk("rx_error", bus.rx_error, e.rxerr);
          chk("ts_sec", bus.timestamp_sec, e.sec);
          chk("ts_nsec", bus.timestamp_nsec, e.nsec);
          for (int w = 0; w < DEPTH; w++) begin
            if (known[w]) begin
              bus.rd_addr = w[AW-1:0];
              @(negedge clk);
              chk($sformatf("word%0d", w), bus.rd_data, mdl[w]);
            end
          end
          chk("done_held", bus.done, 1);
        end
        n_mon++;
      end
      prev = bus.done;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int len;
    int er;
    bus.gmii_rxd   = 8'h00;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    bus.arm        = 1'b0;
    bus.ts_sec     = '0;
    bus.ts_nsec    = '0;
    bus.rd_addr    = '0;
    #2;
    chk_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    chk("idle_not_busy", bus.busy, 0);

    fill_seq(64);
    do_arm();
    send_frame(7, -1);

    fill_rand(1100);
    do_arm();
    send_frame(7, -1);

    fill_seq(66);
    do_arm();
    send_frame(7, -1);

    // Arm while frame A is on the wire: A must be skipped.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h55, 1'b0);
    bus.arm = 1'b1;
    cyc(1'b1, 8'h55, 1'b0);
    bus.arm = 1'b0;
    chk("skip_busy", bus.busy, 1);
    cyc(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'($urandom), 1'b0);
    chk("skip_no_done", bus.done, 0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'hAA);
    send_frame(7, -1);

    fill_rand(40);
    do_arm();
    send_frame(7, 10);

    // Runt preamble: no SFD, stays armed.
    do_arm();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("runt_busy", bus.busy, 1);
    chk("runt_done", bus.done, 0);
    fill_rand(50);
    send_frame(5, -1);

    // Reset in the middle of capture.
    fill_rand(64);
    do_arm();
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, pl[i], 1'b0);
    model_store(20, 1'b1);
    reset = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.gmii_rx_dv = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    chk("post_reset_idle", bus.busy, 0);
    fill_rand(64);
    do_arm();
    send_frame(7, -1);

    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(0, 120);
      er  = (len > 0 && $urandom_range(0, 2) == 0) ?
            $urandom_range(0, len - 1) : -1;
      fill_rand(len);
      do_arm();
      send_frame($urandom_range(0, 7), er);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
